// File: rtl/hilbert_fir_param_if.sv
// Sample/coefficient/result bundle for hilbert_fir_param.
// CAW must equal max(1, $clog2((NTAPS+1)/4)) of the attached filter.
interface hilbert_fir_param_if #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 13,
  parameter int COEF_W = 16,
  parameter int CAW    = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [CAW-1:0]           coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_re, out_im, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_re, out_im, out_sat
  );
endinterface

// File: rtl/hilbert_fir_param.sv
// Time-multiplexed antisymmetric Hilbert FIR: one shared multiplier walks the
// NH unique coefficients per sample, then emits delayed input and rounded Im.
module hilbert_fir_param #(
  parameter int DATA_W  = 12,
  parameter int OUT_W   = 13,
  parameter int COEF_W  = 16,
  parameter int NTAPS   = 7,
  parameter int H0_INIT = 20480,
  parameter int H1_INIT = 7808
) (
  input logic clock,
  input logic reset,
  hilbert_fir_param_if.slave bus
);
  localparam int M   = (NTAPS - 1) / 2;
  localparam int NH  = (NTAPS + 1) / 4;
  localparam int CAW = ($clog2(NH) < 1) ? 1 : $clog2(NH);
  localparam int DW  = DATA_W + 1;
  localparam int PW  = DATA_W + COEF_W + 1;
  localparam int AW  = PW + $clog2(NH) + 1;

  localparam logic signed [AW-1:0] RND  = AW'(1 <<< (COEF_W - 2));
  localparam logic signed [AW-1:0] OMAX = AW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state, state_nx;
  logic [CAW-1:0]           j;
  logic signed [DATA_W-1:0] x [NTAPS];
  logic signed [COEF_W-1:0] c [NH];
  logic signed [AW-1:0]     acc, acc_fin, rnd;
  logic signed [DATA_W-1:0] xa, xb;
  logic signed [COEF_W-1:0] cj;
  logic signed [DW-1:0]     diff;
  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  im_nx;
  logic                     sat_nx;
  logic                     accept, last;

  assign bus.in_ready = (state == IDLE);
  assign accept       = (state == IDLE) && bus.in_valid;
  assign last         = (state == MAC) && (j == CAW'(NH - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = MAC;
      MAC:     if (last) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pick the symmetric tap pair and coefficient for term j.
  always_comb begin
    xa = '0;
    xb = '0;
    cj = '0;
    for (int unsigned i = 0; i < NH; i++) begin
      if (j == CAW'(i)) begin
        xa = x[M - (2 * i + 1)];
        xb = x[M + (2 * i + 1)];
        cj = c[i];
      end
    end
  end

  always_comb begin
    diff    = DW'(xa) - DW'(xb);
    prod    = PW'(diff) * PW'(cj);
    acc_fin = acc + AW'(prod);
    rnd     = (acc_fin + RND) >>> (COEF_W - 1);
    sat_nx  = 1'b0;
    im_nx   = rnd[OUT_W-1:0];
    if (rnd > OMAX) begin
      im_nx  = OMAX[OUT_W-1:0];
      sat_nx = 1'b1;
    end else if (rnd < OMIN) begin
      im_nx  = OMIN[OUT_W-1:0];
      sat_nx = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) x[k] <= '0;
      for (int unsigned i = 0; i < NH; i++) begin
        if (i == 0)      c[i] <= COEF_W'(H0_INIT);
        else if (i == 1) c[i] <= COEF_W'(H1_INIT);
        else             c[i] <= '0;
      end
      acc           <= '0;
      j             <= '0;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (state == IDLE) begin
        // Out-of-range addresses match no slot and are dropped.
        if (bus.coef_we) begin
          for (int unsigned i = 0; i < NH; i++)
            if (bus.coef_addr == CAW'(i)) c[i] <= bus.coef_data;
        end
        if (accept) begin
          x[0] <= bus.in_data;
          for (int unsigned k = 1; k < NTAPS; k++) x[k] <= x[k-1];
          acc <= '0;
          j   <= '0;
        end
      end else if (state == MAC) begin
        acc <= acc_fin;
        j   <= j + CAW'(1);
        if (last) begin
          bus.out_valid <= 1'b1;
          bus.out_re    <= OUT_W'(x[M]);
          bus.out_im    <= im_nx;
          bus.out_sat   <= sat_nx;
        end
      end
    end
  end
endmodule
